uart_cmd_responder: RTL and testbench
=====================================

Name: uart_cmd_responder

Overview:
Command responder behind the UART string framer, on the FPGA side of the host link. It consumes each received `{{...}}` frame payload (rx_string/rx_length/rx_done) and parses an ASCII hex register command. It executes the command on a simple register bus, then builds the ASCII reply and hands it to the framer's transmit side (tx_string/tx_length/tx_req). This gives the host read/write access to FPGA registers over UART.

Parameters:
MAX_TX_WAIT, 5_000_000, cycles to wait for tx_done after tx_req before abandoning the reply (100 ms at 50 MHz).

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  asynchronous active-low reset
rx_string  in  1024  received payload; byte k at [8k+7:8k]
rx_length  in  8  payload byte count
rx_done  in  1  1-cycle pulse: rx_string/rx_length valid this cycle
tx_string  out  1024  reply payload; byte k at [8k+7:8k]
tx_length  out  8  reply byte count
tx_req  out  1  1-cycle reply request to framer
tx_busy  in  1  framer transmit busy
tx_done  in  1  framer transmit complete pulse
reg_addr  out  8  register address
reg_wdata  out  32  register write data
reg_we  out  1  1-cycle write strobe
reg_re  out  1  1-cycle read strobe
reg_rdata  in  32  read data, valid the cycle after reg_re
busy  out  1  high whenever FSM is not IDLE
frame_drop  out  1  1-cycle pulse: rx_done arrived while busy
cmd_err  out  1  1-cycle pulse in BUILD when an ER reply is formed
tx_timeout  out  1  1-cycle pulse when the MAX_TX_WAIT timeout fires

Behaviour:
- Reset (async, active-low): all outputs 0, FSM in IDLE, internal buffers 0.
- Command grammar: byte0 is the opcode. Hex digits accept 0-9, A-F, a-f, most significant nibble first.
  - Write command: "W" + 2 hex addr + 8 hex data, exactly 11 bytes.
  - Read command: "R" + 2 hex addr, exactly 3 bytes.
- Replies, byte0 first, hex in uppercase:
  - Write: "OK", length 2.
  - Read: "R" + 2 hex addr + 8 hex data, length 11.
  - Any error: "ER", length 2.
- FSM states: IDLE, CHECK, PARSE, EXEC, RDWAIT, BUILD, SEND, WAIT_DONE.
  - IDLE: on rx_done, latch rx_string/rx_length into a buffer → CHECK.
  - CHECK: if opcode/length are valid ('W' with len 11, or 'R' with len 3), set idx=1 → PARSE; otherwise set err → BUILD. Length 0 is an error.
  - PARSE: decode one byte per cycle (buf[idx]). Shift the nibble into addr for idx 1-2, and into data for idx 3-10. A non-hex byte sets err but parsing continues. After the last byte: if err → BUILD, else → EXEC.
  - EXEC: drive reg_addr (and reg_wdata for write) and pulse reg_we or reg_re for one cycle. Write → BUILD; read → RDWAIT.
  - RDWAIT: capture reg_rdata → BUILD.
  - BUILD: register tx_string/tx_length (unused upper bytes = 0) → SEND.
  - SEND: stay while tx_busy=1. In the first cycle with tx_busy=0, tx_req=1 for exactly that cycle, then → WAIT_DONE.
  - WAIT_DONE: on tx_done → IDLE. If MAX_TX_WAIT cycles elapse, pulse tx_timeout → IDLE.
- Latency, with rx_done at cycle T and tx_busy low:
  - Valid write: reg_we at T+12, tx_req at T+14.
  - Valid read: reg_re at T+4, reg_rdata sampled at T+5, tx_req at T+7.
  - Length/opcode error: tx_req at T+3.
  - Bad hex in a write: tx_req at T+13.
- Busy handling: rx_done in any state other than IDLE pulses frame_drop; that frame is ignored and current processing is unaffected.
- reg_addr and reg_wdata hold their last values between commands.
- tx_string and tx_length hold their values until the next BUILD.
- A tx_done seen outside WAIT_DONE is ignored.
- The wait counter is 23 bits, clears on entry to WAIT_DONE and saturates; no wrap.
- Reset asserted mid-command aborts immediately, with no strobe or tx_req afterwards.

Decomposition:
- Package uart_cmd_pkg holds:
  - one-hot state encodings;
  - ASCII constants 'W', 'R', 'O', 'K', 'E';
  - CMD_W_LEN=11, CMD_R_LEN=3;
  - functions hex2nib (returns a valid flag plus the nibble) and nib2hex.
- One natural combinational sub-module, hex_reply_builder: formats addr/data/type into the 1024-bit reply and its length.

Test Plan:
- "W1A0000BEEF" (len 11) → reg_we at T+12 with addr 0x1A, wdata 0x0000BEEF; tx_req at T+14 with "OK", len 2.
- "r1a" with reg_rdata=0xCAFE0001 → reg_re at T+4; tx_string="R1ACAFE0001", len 11; tx_req at T+7.
- "W1G00000000" → no reg_we; "ER", len 2; cmd_err pulse; tx_req at T+13. Also len 0 and "X12" → "ER"; tx_req at T+3.
- rx_done while in WAIT_DONE → frame_drop pulse; reply of the first frame unchanged; no second tx_req.
- tx_busy held high for 100 cycles during SEND → tx_req asserted only in the first cycle after tx_busy falls. With tx_done withheld and MAX_TX_WAIT=50, tx_timeout fires 50 cycles after tx_req, then FSM returns to IDLE and accepts the next frame.
- sys_rst_n asserted during PARSE → all outputs 0; no reg_we/tx_req until a new rx_done.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART register command responder.
// Holds one-hot FSM states, ASCII constants, command lengths and hex conversion.
package uart_cmd_pkg;

   typedef enum logic [7:0] {
      S_IDLE      = 8'b0000_0001,
      S_CHECK     = 8'b0000_0010,
      S_PARSE     = 8'b0000_0100,
      S_EXEC      = 8'b0000_1000,
      S_RDWAIT    = 8'b0001_0000,
      S_BUILD     = 8'b0010_0000,
      S_SEND      = 8'b0100_0000,
      S_WAIT_DONE = 8'b1000_0000
   } state_e;

   localparam logic [7:0] ASCII_W = 8'h57;
   localparam logic [7:0] ASCII_R = 8'h52;
   localparam logic [7:0] ASCII_O = 8'h4F;
   localparam logic [7:0] ASCII_K = 8'h4B;
   localparam logic [7:0] ASCII_E = 8'h45;

   localparam logic [7:0] CMD_W_LEN = 8'd11;
   localparam logic [7:0] CMD_R_LEN = 8'd3;

   typedef struct packed {
      logic       vld;
      logic [3:0] nib;
   } hex_nib_t;

   function automatic hex_nib_t hex2nib(input logic [7:0] c);
      hex_nib_t r;
      r.vld = 1'b1;
      r.nib = 4'h0;
      if (c >= 8'h30 && c <= 8'h39)      r.nib = 4'(c - 8'h30);
      else if (c >= 8'h41 && c <= 8'h46) r.nib = 4'(c - 8'h37);
      else if (c >= 8'h61 && c <= 8'h66) r.nib = 4'(c - 8'h57);
      else                               r.vld = 1'b0;
      return r;
   endfunction

   function automatic logic [7:0] nib2hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

endpackage

// File: rtl/uart_cmd_responder_hex_reply_builder.sv
// Combinational reply formatter: "ER", "OK", or "R"+addr+data in uppercase hex.
// Zero latency; unused upper bytes are forced to zero.
module hex_reply_builder
   import uart_cmd_pkg::*;
(
   input  logic          is_read_i,
   input  logic          err_i,
   input  logic [7:0]    addr_i,
   input  logic [31:0]   data_i,
   output logic [1023:0] str_o,
   output logic [7:0]    len_o
);

   always_comb begin
      str_o = '0;
      len_o = 8'd2;
      if (err_i) begin
         str_o[7:0]  = ASCII_E;
         str_o[15:8] = ASCII_R;
      end else if (is_read_i) begin
         str_o[7:0]   = ASCII_R;
         str_o[15:8]  = nib2hex(addr_i[7:4]);
         str_o[23:16] = nib2hex(addr_i[3:0]);
         for (int k = 0; k < 8; k++)
            str_o[24 + 8*k +: 8] = nib2hex(data_i[31 - 4*k -: 4]);
         len_o = CMD_W_LEN;
      end else begin
         str_o[7:0]  = ASCII_O;
         str_o[15:8] = ASCII_K;
      end
   end

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses ASCII hex W/R register commands from framed UART payloads and replies.
// Frames arriving while busy are dropped (frame_drop); reply send waits on tx_busy.
module uart_cmd_responder
   import uart_cmd_pkg::*;
#(
   parameter int unsigned MAX_TX_WAIT = 5_000_000
) (
   input  logic          sys_clk,
   input  logic          sys_rst_n,
   input  logic [1023:0] rx_string,
   input  logic [7:0]    rx_length,
   input  logic          rx_done,
   output logic [1023:0] tx_string,
   output logic [7:0]    tx_length,
   output logic          tx_req,
   input  logic          tx_busy,
   input  logic          tx_done,
   output logic [7:0]    reg_addr,
   output logic [31:0]   reg_wdata,
   output logic          reg_we,
   output logic          reg_re,
   input  logic [31:0]   reg_rdata,
   output logic          busy,
   output logic          frame_drop,
   output logic          cmd_err,
   output logic          tx_timeout
);

   localparam logic [22:0] TMO_LAST = 23'(MAX_TX_WAIT - 1);

   state_e         state_q;
   logic [127:0]   buf_q;
   logic [7:0]     len_q;
   logic [3:0]     idx_q;
   logic           err_q, is_rd_q;
   logic [7:0]     addr_q, reg_addr_q;
   logic [31:0]    data_q, rdata_q, reg_wdata_q;
   logic           reg_we_q, reg_re_q, frame_drop_q, cmd_err_q, tx_timeout_q;
   logic [1023:0]  tx_string_q;
   logic [7:0]     tx_length_q;
   logic [22:0]    cnt_q;

   // Only the first 16 bytes can ever form a legal command.
   logic unused_rx_hi;
   assign unused_rx_hi = ^rx_string[1023:128];

   logic [7:0]    cur_byte, opc;
   hex_nib_t      cur_nib;
   logic [3:0]    last_idx;
   logic [7:0]    addr_d;
   logic [31:0]   data_d;
   logic          op_w, op_r;
   logic [1023:0] bld_str;
   logic [7:0]    bld_len;

   assign cur_byte = buf_q[{idx_q, 3'b000} +: 8];
   assign cur_nib  = hex2nib(cur_byte);
   assign last_idx = is_rd_q ? 4'd2 : 4'd10;
   assign addr_d   = (idx_q <= 4'd2) ? {addr_q[3:0], cur_nib.nib} : addr_q;
   assign data_d   = (idx_q >= 4'd3) ? {data_q[27:0], cur_nib.nib} : data_q;
   assign opc      = buf_q[7:0];
   // Opcode letter is accepted in either case.
   assign op_w     = ((opc | 8'h20) == (ASCII_W | 8'h20)) && (len_q == CMD_W_LEN);
   assign op_r     = ((opc | 8'h20) == (ASCII_R | 8'h20)) && (len_q == CMD_R_LEN);

   hex_reply_builder u_bld (
      .is_read_i (is_rd_q),
      .err_i     (err_q),
      .addr_i    (addr_q),
      .data_i    (rdata_q),
      .str_o     (bld_str),
      .len_o     (bld_len)
   );

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q      <= S_IDLE;
         buf_q        <= '0;
         len_q        <= '0;
         idx_q        <= '0;
         err_q        <= 1'b0;
         is_rd_q      <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
         rdata_q      <= '0;
         reg_addr_q   <= '0;
         reg_wdata_q  <= '0;
         reg_we_q     <= 1'b0;
         reg_re_q     <= 1'b0;
         frame_drop_q <= 1'b0;
         cmd_err_q    <= 1'b0;
         tx_timeout_q <= 1'b0;
         tx_string_q  <= '0;
         tx_length_q  <= '0;
         cnt_q        <= '0;
      end else begin
         reg_we_q     <= 1'b0;
         reg_re_q     <= 1'b0;
         cmd_err_q    <= 1'b0;
         tx_timeout_q <= 1'b0;
         frame_drop_q <= rx_done && (state_q != S_IDLE);
         case (state_q)
            S_IDLE: if (rx_done) begin
               buf_q   <= rx_string[127:0];
               len_q   <= rx_length;
               state_q <= S_CHECK;
            end
            S_CHECK: begin
               idx_q   <= 4'd1;
               addr_q  <= '0;
               data_q  <= '0;
               is_rd_q <= op_r;
               if (op_w || op_r) begin
                  err_q   <= 1'b0;
                  state_q <= S_PARSE;
               end else begin
                  err_q     <= 1'b1;
                  cmd_err_q <= 1'b1;
                  state_q   <= S_BUILD;
               end
            end
            S_PARSE: begin
               addr_q <= addr_d;
               data_q <= data_d;
               idx_q  <= idx_q + 4'd1;
               if (!cur_nib.vld) err_q <= 1'b1;
               if (idx_q == last_idx) begin
                  if (err_q || !cur_nib.vld) begin
                     cmd_err_q <= 1'b1;
                     state_q   <= S_BUILD;
                  end else begin
                     // Bus outputs and strobe are registered on entry so they show during EXEC.
                     reg_addr_q <= addr_d;
                     if (is_rd_q) reg_re_q <= 1'b1;
                     else begin
                        reg_we_q    <= 1'b1;
                        reg_wdata_q <= data_d;
                     end
                     state_q <= S_EXEC;
                  end
               end
            end
            S_EXEC:   state_q <= is_rd_q ? S_RDWAIT : S_BUILD;
            S_RDWAIT: begin
               rdata_q <= reg_rdata;
               state_q <= S_BUILD;
            end
            S_BUILD: begin
               tx_string_q <= bld_str;
               tx_length_q <= bld_len;
               state_q     <= S_SEND;
            end
            S_SEND: if (!tx_busy) begin
               cnt_q   <= '0;
               state_q <= S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
               if (tx_done) state_q <= S_IDLE;
               else if (cnt_q == TMO_LAST) begin
                  tx_timeout_q <= 1'b1;
                  state_q      <= S_IDLE;
               end else if (cnt_q != '1) cnt_q <= cnt_q + 23'd1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // tx_req must fall in the very cycle tx_busy is first seen low, so it is decoded from state.
   assign tx_req     = (state_q == S_SEND) && !tx_busy;
   assign busy       = (state_q != S_IDLE);
   assign tx_string  = tx_string_q;
   assign tx_length  = tx_length_q;
   assign reg_addr   = reg_addr_q;
   assign reg_wdata  = reg_wdata_q;
   assign reg_we     = reg_we_q;
   assign reg_re     = reg_re_q;
   assign frame_drop = frame_drop_q;
   assign cmd_err    = cmd_err_q;
   assign tx_timeout = tx_timeout_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench: stimulus queues expected bus strobes and replies, a monitor checks them.
// Cycle numbers count intervals after each rising edge; T is the interval holding rx_done.
module tb_uart_cmd_responder;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [1023:0] rx_string = '0;
   logic [7:0]    rx_length = '0;
   logic          rx_done = 1'b0;
   logic [1023:0] tx_string;
   logic [7:0]    tx_length;
   logic          tx_req;
   logic          tx_busy = 1'b0;
   logic          tx_done = 1'b0;
   logic [7:0]    reg_addr;
   logic [31:0]   reg_wdata;
   logic          reg_we, reg_re;
   logic [31:0]   reg_rdata = 32'hCAFE0001;
   logic          busy, frame_drop, cmd_err, tx_timeout;

   uart_cmd_responder #(.MAX_TX_WAIT(50)) dut (
      .sys_clk(clk), .sys_rst_n(rst_n),
      .rx_string(rx_string), .rx_length(rx_length), .rx_done(rx_done),
      .tx_string(tx_string), .tx_length(tx_length), .tx_req(tx_req),
      .tx_busy(tx_busy), .tx_done(tx_done),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
      .reg_rdata(reg_rdata), .busy(busy), .frame_drop(frame_drop),
      .cmd_err(cmd_err), .tx_timeout(tx_timeout)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct { int cyc; logic [1023:0] str; logic [7:0] len; } tx_exp_t;
   typedef struct { int cyc; logic [7:0] a; logic [31:0] d; } bus_exp_t;
   tx_exp_t  txq[$];
   bus_exp_t weq[$];
   bus_exp_t req[$];
   int       errq[$];
   int       dropq[$];
   int       tmoq[$];

   bit tx_auto = 1'b1;
   int tx_done_delay = 3;

   function automatic logic [1023:0] mk_str(input string s);
      logic [1023:0] r;
      r = '0;
      for (int k = 0; k < s.len(); k++) r[8*k +: 8] = s[k];
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_frame(input string s, output int t);
      @(posedge clk); #1;
      rx_string = mk_str(s);
      rx_length = 8'(s.len());
      rx_done   = 1'b1;
      t = cyc;
      @(posedge clk); #1;
      rx_done = 1'b0;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin @(posedge clk); #1; n++; end
      chk("idle_within_budget", 128'(n < budget), 128'(1));
   endtask

   task automatic push_tx(input int c, input string s);
      tx_exp_t e;
      e.cyc = c; e.str = mk_str(s); e.len = 8'(s.len());
      txq.push_back(e);
   endtask

   task automatic push_bus(input bit is_we, input int c, input logic [7:0] a, input logic [31:0] d);
      bus_exp_t e;
      e.cyc = c; e.a = a; e.d = d;
      if (is_we) weq.push_back(e); else req.push_back(e);
   endtask

   // Framer model: answers each tx_req with a tx_done pulse after a delay.
   initial forever begin
      @(negedge clk);
      if (tx_req && tx_auto && rst_n) begin
         repeat (tx_done_delay) @(posedge clk);
         #1 tx_done = 1'b1;
         @(posedge clk); #1 tx_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      bus_exp_t be;
      tx_exp_t  te;
      int       c;
      if (rst_n) begin
         if (reg_we) begin
            tests++;
            if (weq.size() == 0) begin fails++; $display("FAIL unexpected_reg_we: cycle %0d addr %h", cyc, reg_addr); end
            else begin
               be = weq.pop_front();
               if (be.cyc != cyc || reg_addr !== be.a || reg_wdata !== be.d) begin
                  fails++;
                  $display("FAIL reg_we: got cyc %0d addr %h data %h, expected cyc %0d addr %h data %h",
                           cyc, reg_addr, reg_wdata, be.cyc, be.a, be.d);
               end
            end
         end
         if (reg_re) begin
            tests++;
            if (req.size() == 0) begin fails++; $display("FAIL unexpected_reg_re: cycle %0d addr %h", cyc, reg_addr); end
            else begin
               be = req.pop_front();
               if (be.cyc != cyc || reg_addr !== be.a) begin
                  fails++;
                  $display("FAIL reg_re: got cyc %0d addr %h, expected cyc %0d addr %h", cyc, reg_addr, be.cyc, be.a);
               end
            end
         end
         if (tx_req) begin
            tests++;
            if (txq.size() == 0) begin fails++; $display("FAIL unexpected_tx_req: cycle %0d", cyc); end
            else begin
               te = txq.pop_front();
               if (te.cyc != cyc || tx_string !== te.str || tx_length !== te.len) begin
                  fails++;
                  $display("FAIL tx_req: got cyc %0d len %0d str %h, expected cyc %0d len %0d str %h",
                           cyc, tx_length, tx_string[127:0], te.cyc, te.len, te.str[127:0]);
               end
            end
         end
         if (cmd_err) begin
            tests++;
            c = (errq.size() == 0) ? -1 : errq.pop_front();
            if (c != cyc) begin fails++; $display("FAIL cmd_err: got cycle %0d expected %0d", cyc, c); end
         end
         if (frame_drop) begin
            tests++;
            c = (dropq.size() == 0) ? -1 : dropq.pop_front();
            if (c != cyc) begin fails++; $display("FAIL frame_drop: got cycle %0d expected %0d", cyc, c); end
         end
         if (tx_timeout) begin
            tests++;
            c = (tmoq.size() == 0) ? -100 : tmoq.pop_front();
            if (cyc != c && cyc != c + 1) begin
               fails++;
               $display("FAIL tx_timeout: got cycle %0d expected %0d or %0d", cyc, c, c + 1);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "global timeout");
   end

   initial begin
      int t, t2;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_tx_req", 128'(tx_req), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_strobes", 128'({reg_we, reg_re, frame_drop, cmd_err, tx_timeout}), 128'(0));
      chk("rst_tx_length", 128'(tx_length), 128'(0));
      chk("rst_tx_string_any", 128'(|tx_string), 128'(0));
      chk("rst_reg_bus", 128'({reg_addr, reg_wdata}), 128'(0));
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      // Write: strobe at T+12, OK at T+14.
      send_frame("W1A0000BEEF", t);
      push_bus(1'b1, t + 12, 8'h1A, 32'h0000BEEF);
      push_tx(t + 14, "OK");
      wait_idle(100);

      // Lower-case read: strobe T+4, reply T+7.
      send_frame("r1a", t);
      push_bus(1'b0, t + 4, 8'h1A, 32'h0);
      push_tx(t + 7, "R1ACAFE0001");
      wait_idle(100);
      chk("wdata_holds_after_read", 128'(reg_wdata), 128'(32'h0000BEEF));

      // Bad hex in a write: no strobe, ER at T+13.
      send_frame("W1G00000000", t);
      errq.push_back(t + 12);
      push_tx(t + 13, "ER");
      wait_idle(100);

      send_frame("", t);
      errq.push_back(t + 2);
      push_tx(t + 3, "ER");
      wait_idle(100);

      send_frame("X12", t);
      errq.push_back(t + 2);
      push_tx(t + 3, "ER");
      wait_idle(100);

      // Second frame while waiting for tx_done is dropped.
      tx_done_delay = 10;
      send_frame("R05", t);
      push_bus(1'b0, t + 4, 8'h05, 32'h0);
      push_tx(t + 7, "R05CAFE0001");
      wait_cyc(t + 8);
      send_frame("W0100000001", t2);
      chk("drop_frame_cycle", 128'(t2), 128'(t + 9));
      dropq.push_back(t2 + 1);
      wait_idle(100);
      chk("drop_reply_unchanged", tx_string[127:0], mk_str("R05CAFE0001") >> 0);
      chk("drop_len_unchanged", 128'(tx_length), 128'(11));
      tx_done_delay = 3;

      // Busy framer for 100 cycles, then no tx_done: timeout 50 cycles on.
      tx_busy = 1'b1;
      tx_auto = 1'b0;
      send_frame("W0200000002", t);
      push_bus(1'b1, t + 12, 8'h02, 32'h00000002);
      push_tx(t + 100, "OK");
      wait_cyc(t + 99);
      @(posedge clk); #1 tx_busy = 1'b0;
      tmoq.push_back(t + 150);
      wait_idle(100);
      tx_auto = 1'b1;
      send_frame("R33", t);
      push_bus(1'b0, t + 4, 8'h33, 32'h0);
      push_tx(t + 7, "R33CAFE0001");
      wait_idle(100);

      // Reset in the middle of PARSE.
      send_frame("W1A0000BEEF", t);
      wait_cyc(t + 4);
      @(posedge clk); #1 rst_n = 1'b0;
      @(negedge clk);
      chk("midrst_busy_req", 128'({busy, tx_req}), 128'(0));
      chk("midrst_strobes", 128'({reg_we, reg_re, cmd_err}), 128'(0));
      chk("midrst_tx_length", 128'(tx_length), 128'(0));
      chk("midrst_reg_bus", 128'({reg_addr, reg_wdata}), 128'(0));
      repeat (2) @(posedge clk); #1 rst_n = 1'b1;
      repeat (20) @(posedge clk); #1;
      chk("post_rst_idle", 128'(busy), 128'(0));
      reg_rdata = 32'h12345678;
      send_frame("R7f", t);
      push_bus(1'b0, t + 4, 8'h7F, 32'h0);
      push_tx(t + 7, "R7F12345678");
      wait_idle(100);

      repeat (5) @(posedge clk); #1;
      chk("left_tx", 128'(txq.size()), 128'(0));
      chk("left_we_re", 128'(weq.size() + req.size()), 128'(0));
      chk("left_pulses", 128'(errq.size() + dropq.size() + tmoq.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
